// File: rtl/genesis_pad_pkg.sv
// ============================================================================
//  Module      : genesis_pad_pkg
//  Description : Shared constants for the Genesis/Mega Drive pad reader:
//                SELECT phase encoding, pin and button bit indices.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package genesis_pad_pkg;

    localparam int NUM_PHASES = 8;
    localparam int BTN_W      = 12;
    localparam int PIN_W      = 6;

    typedef enum logic [2:0] {
        PH_0 = 3'd0,
        PH_1 = 3'd1,
        PH_2 = 3'd2,
        PH_3 = 3'd3,
        PH_4 = 3'd4,
        PH_5 = 3'd5,
        PH_6 = 3'd6,
        PH_7 = 3'd7
    } phase_e;

    // Bit positions inside the synchronised pin vector
    localparam int PIDX_UP_Z       = 0;
    localparam int PIDX_DOWN_Y     = 1;
    localparam int PIDX_LEFT_X     = 2;
    localparam int PIDX_RIGHT_MODE = 3;
    localparam int PIDX_A_B        = 4;
    localparam int PIDX_START_C    = 5;

    localparam int BTN_UP    = 0;
    localparam int BTN_DOWN  = 1;
    localparam int BTN_LEFT  = 2;
    localparam int BTN_RIGHT = 3;
    localparam int BTN_A     = 4;
    localparam int BTN_B     = 5;
    localparam int BTN_C     = 6;
    localparam int BTN_START = 7;
    localparam int BTN_X     = 8;
    localparam int BTN_Y     = 9;
    localparam int BTN_Z     = 10;
    localparam int BTN_MODE  = 11;

    function automatic phase_e next_phase(input phase_e p);
        return phase_e'(p + 3'd1);
    endfunction

endpackage : genesis_pad_pkg

`default_nettype wire

// File: rtl/genesis_pad_reader_pad_pin_sync.sv
// ============================================================================
//  Module      : pad_pin_sync
//  Description : Two-flop synchroniser for the six asynchronous pad pins.
//                Resets to all-ones so an idle/absent pad reads as released.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module pad_pin_sync
    import genesis_pad_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic [PIN_W-1:0] pins_async,
    output logic [PIN_W-1:0] pins_sync
);

    logic [PIN_W-1:0] meta_d;
    logic [PIN_W-1:0] meta_q;
    logic [PIN_W-1:0] sync_d;
    logic [PIN_W-1:0] sync_q;

    always_comb begin
        meta_d = pins_async;
        sync_d = meta_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q <= '1;
            sync_q <= '1;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign pins_sync = sync_q;

endmodule : pad_pin_sync

`default_nettype wire

// File: rtl/genesis_pad_reader.sv
// ============================================================================
//  Module      : genesis_pad_reader
//  Description : Scans a 3/6-button Genesis pad over an 8-phase SELECT frame
//                and publishes a 12-bit active-high button vector per frame.
//                Optional macro GENESIS_PAD_DEBOUNCE_EN: commit only when two
//                consecutive frames agree.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module genesis_pad_reader
    import genesis_pad_pkg::*;
#(
    parameter int PHASE_TICKS = 1000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             PIN_UP_Z,
    input  logic             PIN_DOWN_Y,
    input  logic             PIN_LEFT_X,
    input  logic             PIN_RIGHT_MODE,
    input  logic             PIN_A_B,
    input  logic             PIN_START_C,
    input  logic             block,
    output logic             select,
    output logic [BTN_W-1:0] LEDR
);

    localparam int                TICK_W    = (PHASE_TICKS > 1) ? $clog2(PHASE_TICKS) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(PHASE_TICKS - 1);
    localparam logic [TICK_W-1:0] TICK_ONE  = TICK_W'(1);

    logic [PIN_W-1:0]  pins_async;
    logic [PIN_W-1:0]  pins_sync;
    logic [PIN_W-1:0]  pin_pressed;

    logic [TICK_W-1:0] tick_d;
    logic [TICK_W-1:0] tick_q;
    phase_e            phase_d;
    phase_e            phase_q;
    logic [2:0]        phase_bits_d;
    logic              select_d;
    logic              select_q;
    logic [BTN_W-1:0]  shadow_d;
    logic [BTN_W-1:0]  shadow_q;
    logic              six_btn_d;
    logic              six_btn_q;
    logic [BTN_W-1:0]  ledr_d;
    logic [BTN_W-1:0]  ledr_q;
    logic [BTN_W-1:0]  frame_vec;
    logic              last_tick;
    logic              commit_ok;
`ifdef GENESIS_PAD_DEBOUNCE_EN
    logic [BTN_W-1:0]  prev_d;
    logic [BTN_W-1:0]  prev_q;
`endif

    assign pins_async = {PIN_START_C, PIN_A_B, PIN_RIGHT_MODE, PIN_LEFT_X, PIN_DOWN_Y, PIN_UP_Z};

    pad_pin_sync u_pin_sync (
        .clk        (clk),
        .reset      (reset),
        .pins_async (pins_async),
        .pins_sync  (pins_sync)
    );

    assign pin_pressed = ~pins_sync;
    assign last_tick   = (tick_q == TICK_LAST);

    // A 3-button pad never reports X/Y/Z/MODE, so those bits are masked
    assign frame_vec = {(six_btn_q ? shadow_q[BTN_MODE:BTN_X] : 4'b0000), shadow_q[BTN_START:BTN_UP]};

`ifdef GENESIS_PAD_DEBOUNCE_EN
    assign commit_ok = !block && (frame_vec == prev_q);
`else
    assign commit_ok = !block;
`endif

    always_comb begin
        tick_d    = tick_q + TICK_ONE;
        phase_d   = phase_q;
        shadow_d  = shadow_q;
        six_btn_d = six_btn_q;
        ledr_d    = ledr_q;
`ifdef GENESIS_PAD_DEBOUNCE_EN
        prev_d    = prev_q;
`endif

        if (last_tick) begin
            tick_d  = '0;
            phase_d = next_phase(phase_q);

            // Sample at the end of each phase so the pad has had a full phase to settle
            case (phase_q)
                PH_1: begin
                    shadow_d[BTN_UP]    = pin_pressed[PIDX_UP_Z];
                    shadow_d[BTN_DOWN]  = pin_pressed[PIDX_DOWN_Y];
                    shadow_d[BTN_LEFT]  = pin_pressed[PIDX_LEFT_X];
                    shadow_d[BTN_RIGHT] = pin_pressed[PIDX_RIGHT_MODE];
                    shadow_d[BTN_B]     = pin_pressed[PIDX_A_B];
                    shadow_d[BTN_C]     = pin_pressed[PIDX_START_C];
                end
                PH_2: begin
                    shadow_d[BTN_A]     = pin_pressed[PIDX_A_B];
                    shadow_d[BTN_START] = pin_pressed[PIDX_START_C];
                end
                PH_4: begin
                    six_btn_d = pin_pressed[PIDX_UP_Z] & pin_pressed[PIDX_DOWN_Y];
                end
                PH_5: begin
                    shadow_d[BTN_Z]    = pin_pressed[PIDX_UP_Z];
                    shadow_d[BTN_Y]    = pin_pressed[PIDX_DOWN_Y];
                    shadow_d[BTN_X]    = pin_pressed[PIDX_LEFT_X];
                    shadow_d[BTN_MODE] = pin_pressed[PIDX_RIGHT_MODE];
                end
                PH_7: begin
                    if (commit_ok) begin
                        ledr_d = frame_vec;
                    end
`ifdef GENESIS_PAD_DEBOUNCE_EN
                    prev_d = frame_vec;
`endif
                end
                default: begin
                end
            endcase
        end

        phase_bits_d = phase_d;
        select_d     = phase_bits_d[0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tick_q    <= '0;
            phase_q   <= PH_0;
            select_q  <= 1'b0;
            shadow_q  <= '0;
            six_btn_q <= 1'b0;
            ledr_q    <= '0;
`ifdef GENESIS_PAD_DEBOUNCE_EN
            prev_q    <= '0;
`endif
        end else begin
            tick_q    <= tick_d;
            phase_q   <= phase_d;
            select_q  <= select_d;
            shadow_q  <= shadow_d;
            six_btn_q <= six_btn_d;
            ledr_q    <= ledr_d;
`ifdef GENESIS_PAD_DEBOUNCE_EN
            prev_q    <= prev_d;
`endif
        end
    end

    assign select = select_q;
    assign LEDR   = ledr_q;

endmodule : genesis_pad_reader

`default_nettype wire

// File: tb/tb_genesis_pad_reader.sv
// ============================================================================
//  Module      : tb_genesis_pad_reader
//  Description : Directed bench for genesis_pad_reader with a small 3/6-button
//                pad emulator driven from the bench's own frame timing.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_genesis_pad_reader;

    localparam int PT    = 20;
    localparam int FRAME = 8 * PT;
    localparam int SETTLE = 3 * FRAME + 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        block;
    logic        select;
    logic [11:0] LEDR;
    logic [5:0]  pad_pins;

    logic        raw_en;
    logic [5:0]  raw_pins;
    logic        id_en;
    logic        xb_en;
    logic [11:0] pressed;
    int unsigned cyc;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic        raw;
        logic [5:0]  raw_pins;
        logic        id_en;
        logic        xb_en;
        logic [11:0] pressed;
        logic [11:0] exp;
    } vec_t;

    vec_t vecs[10];

    always #10 clk = ~clk;

    genesis_pad_reader #(.PHASE_TICKS(PT)) dut (
        .clk            (clk),
        .reset          (reset),
        .PIN_UP_Z       (pad_pins[0]),
        .PIN_DOWN_Y     (pad_pins[1]),
        .PIN_LEFT_X     (pad_pins[2]),
        .PIN_RIGHT_MODE (pad_pins[3]),
        .PIN_A_B        (pad_pins[4]),
        .PIN_START_C    (pad_pins[5]),
        .block          (block),
        .select         (select),
        .LEDR           (LEDR)
    );

    // Bench-side frame position: count of clock edges since reset released
    always @(posedge clk) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    // Pad emulator; pin order {START_C, A_B, RIGHT_MODE, LEFT_X, DOWN_Y, UP_Z}
    always_comb begin
        int unsigned ph;
        logic [3:0]  dir;
        logic        ab;
        logic        sc;
        ph  = (cyc / PT) % 8;
        dir = 4'b0000;
        ab  = 1'b0;
        sc  = 1'b0;
        if (ph % 2 == 1) begin
            if (ph == 5 && xb_en) dir = {pressed[11], pressed[8], pressed[9], pressed[10]};
            else                  dir = pressed[3:0];
            ab = pressed[5];
            sc = pressed[6];
        end else begin
            if (ph == 4 && id_en) dir = 4'b1111;
            else                  dir = {2'b11, pressed[1], pressed[0]};
            ab = pressed[4];
            sc = pressed[7];
        end
        pad_pins = raw_en ? raw_pins : ~{sc, ab, dir};
    end

    task automatic check(input string name, input logic [11:0] got, input logic [11:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, got, want);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_raw(input logic [5:0] p);
        raw_en   = 1'b1;
        raw_pins = p;
        pressed  = '0;
    endtask

    initial begin
        vecs[0] = '{1'b1, 6'b111111, 1'b0, 1'b0, 12'h000, 12'h000};
        vecs[1] = '{1'b1, 6'b111110, 1'b0, 1'b0, 12'h000, 12'h001};
        vecs[2] = '{1'b0, 6'b111111, 1'b1, 1'b1, 12'h200, 12'h200};
        vecs[3] = '{1'b0, 6'b111111, 1'b0, 1'b1, 12'h200, 12'h000};
        vecs[4] = '{1'b0, 6'b111111, 1'b0, 1'b0, 12'h010, 12'h010};
        vecs[5] = '{1'b0, 6'b111111, 1'b0, 1'b0, 12'h040, 12'h040};
        vecs[6] = '{1'b0, 6'b111111, 1'b1, 1'b1, 12'h9A1, 12'h9A1};
        // 3-button pad holding UP+DOWN mimics the ID pattern, so X/Y/Z/MODE light up
        vecs[7] = '{1'b0, 6'b111111, 1'b0, 1'b0, 12'h0FF, 12'hFFF};
        vecs[8] = '{1'b0, 6'b111111, 1'b1, 1'b1, 12'hFFF, 12'hFFF};
        vecs[9] = '{1'b0, 6'b111111, 1'b1, 1'b1, 12'h656, 12'h656};

        reset    = 1'b1;
        block    = 1'b0;
        id_en    = 1'b0;
        xb_en    = 1'b0;
        set_raw(6'b111111);

        cycles(25);
        check("reset_select", {11'd0, select}, 12'h000);
        check("reset_ledr", LEDR, 12'h000);

        // UP held from release: select cadence and first-commit latency
        set_raw(6'b111110);
        reset = 1'b0;
        cycles(PT - 1);
        check("sel_ph0_end", {11'd0, select}, 12'h000);
        cycles(1);
        check("sel_ph1_start", {11'd0, select}, 12'h001);
        cycles(PT - 1);
        check("sel_ph1_end", {11'd0, select}, 12'h001);
        cycles(1);
        check("sel_ph2_start", {11'd0, select}, 12'h000);
        begin
            int waited;
            waited = 2 * PT;
            while (LEDR !== 12'h001 && waited < 2 * FRAME + 2) begin
                cycles(1);
                waited++;
            end
            check("up_latency", LEDR, 12'h001);
        end

        for (int i = 0; i < 10; i++) begin
            raw_en   = vecs[i].raw;
            raw_pins = vecs[i].raw_pins;
            id_en    = vecs[i].id_en;
            xb_en    = vecs[i].xb_en;
            pressed  = vecs[i].pressed;
            cycles(SETTLE);
            check($sformatf("vec%0d", i), LEDR, vecs[i].exp);
        end

        // block freezes the output while the scan keeps running
        set_raw(6'b111110);
        cycles(SETTLE);
        check("block_pre", LEDR, 12'h001);
        block = 1'b1;
        set_raw(6'b111111);
        cycles(SETTLE);
        check("block_hold", LEDR, 12'h001);
        block = 1'b0;
        cycles(SETTLE);
        check("block_release", LEDR, 12'h000);

        // Reset in the middle of phase 5 with every button held
        raw_en  = 1'b0;
        id_en   = 1'b1;
        xb_en   = 1'b1;
        pressed = 12'hFFF;
        cycles(SETTLE);
        check("midrst_pre", LEDR, 12'hFFF);
        begin
            int guard;
            guard = 0;
            while (((cyc / PT) % 8 != 5 || cyc % PT != PT / 2) && guard < 2 * FRAME) begin
                cycles(1);
                guard++;
            end
            if (guard >= 2 * FRAME) begin
                n_cmp++;
                n_bad++;
                $display("FAIL midrst_align: got timeout, expected phase 5");
            end
        end
        check("midrst_sel_before", {11'd0, select}, 12'h001);
        reset = 1'b1;
        cycles(1);
        check("midrst_ledr", LEDR, 12'h000);
        check("midrst_sel", {11'd0, select}, 12'h000);
        cycles(3);
        reset = 1'b0;
        cycles(PT - 1);
        check("restart_ph0", {11'd0, select}, 12'h000);
        cycles(1);
        check("restart_ph1", {11'd0, select}, 12'h001);
        cycles(SETTLE);
        check("restart_ledr", LEDR, 12'hFFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_genesis_pad_reader

`default_nettype wire
